seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a multi-digit common-segment 7-segment display on the board's `pio` GPIO header. It shares one segment bus among `N_DIGITS` digit enables, with a blanking gap between digits to suppress ghosting. Digit values load into a shadow register only at frame boundaries, through a request/acknowledge handshake. It sits between the hex value producers (counters, button logic) and the `pio` pins in `top`.

---
 rtl/seven_seg_pkg.sv | 40 ++++
 rtl/seven_seg_hex_decoder.sv | 24 ++
 rtl/seven_seg_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

   typedef enum logic {
      GAP  = 1'b0,
      SHOW = 1'b1
   } scan_state_e;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned NIB_W  = 4;

   localparam int unsigned SEG_G = 6;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_A = 4;
   localparam int unsigned SEG_B = 3;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 1;
   localparam int unsigned SEG_E = 0;

   // Active-high gfabcde patterns, indexed by hex value (entry 15 listed first).
   localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
      7'b1110001,   // F
      7'b1110011,   // E
      7'b1001111,   // d
      7'b0110011,   // C
      7'b1100111,   // b
      7'b1111101,   // A
      7'b1111110,   // 9
      7'b1111111,   // 8
      7'b0011100,   // 7
      7'b1110111,   // 6
      7'b1110110,   // 5
      7'b1101100,   // 4
      7'b1011110,   // 3
      7'b1011011,   // 2
      7'b0001100,   // 1
      7'b0111111    // 0
   };

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational hex nibble to gfabcde segment decoder.
module seven_seg_hex_decoder
   import seven_seg_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output logic [SEG_W-1:0] seg_c
);

   logic [SEG_W-1:0] row;

   // Gather each segment by name so the bus ordering lives in one place.
   always_comb begin
      row          = SEG_TABLE[nibble];
      seg_c        = '0;
      seg_c[SEG_G] = row[SEG_G];
      seg_c[SEG_F] = row[SEG_F];
      seg_c[SEG_A] = row[SEG_A];
      seg_c[SEG_B] = row[SEG_B];
      seg_c[SEG_C] = row[SEG_C];
      seg_c[SEG_D] = row[SEG_D];
      seg_c[SEG_E] = row[SEG_E];
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous shadow load.
// Optional leading-zero blanking: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned DWELL_CYCLES = 50000,
   parameter int unsigned GAP_CYCLES   = 500
)(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [4*N_DIGITS-1:0]     digits,
   input  logic                      upd_req,
   output logic                      upd_ack,
   output logic [SEG_W-1:0]          seg,
   output logic [N_DIGITS-1:0]       dig_en,
   output logic                      frame_start
);

   localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

   scan_state_e               state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0]     shadow_q;
   logic                      pending_q, pending_d;
   logic                      en_q;
   logic                      wrap, restart, frame_d, load;
   logic [SEG_W-1:0]          seg_d, dec_seg_c;
   logic [N_DIGITS-1:0]       dig_en_d;
   logic [NIB_W-1:0]          nibble;
   logic [N_DIGITS-1:0]       blank;

`ifdef SEVEN_SEG_LZ_BLANK_EN
   logic lead;

   // A digit blanks while it and every more-significant digit are zero; digit 0 never blanks.
   always_comb begin
      blank = '0;
      lead  = 1'b1;
      for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
         lead     = lead & (shadow_q[4*i +: 4] == 4'h0);
         blank[i] = lead;
      end
   end
`else
   assign blank = '0;
`endif

   seven_seg_hex_decoder u_dec (
      .nibble (nibble),
      .seg_c  (dec_seg_c)
   );

   // Next-state and next-output logic; outputs are computed for the upcoming state.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q - 1'b1;
      wrap     = 1'b0;
      restart  = enable & ~en_q;

      if (!enable || restart) begin
         state_d = GAP;
         idx_d   = '0;
         cnt_d   = GAP_LOAD;
      end else if (cnt_q == '0) begin
         if (state_q == GAP) begin
            state_d = SHOW;
            cnt_d   = DWELL_LOAD;
         end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            if (idx_q == IDX_LAST) begin
               idx_d = '0;
               wrap  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      end

      frame_d   = wrap | restart;
      load      = frame_d & (pending_q | upd_req);
      pending_d = (pending_q | upd_req) & ~load;

      // Shadow only changes on GAP entry, so the current shadow is valid for any SHOW entry.
      nibble   = shadow_q[{idx_d, 2'b00} +: 4];
      seg_d    = '0;
      dig_en_d = '0;
      if (state_d == SHOW) begin
         dig_en_d = N_DIGITS'(1) << idx_d;
         if (!blank[idx_d]) seg_d = dec_seg_c;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= GAP;
         idx_q       <= '0;
         cnt_q       <= GAP_LOAD;
         shadow_q    <= '0;
         pending_q   <= 1'b0;
         en_q        <= 1'b1;
         seg         <= '0;
         dig_en      <= '0;
         upd_ack     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         en_q        <= enable;
         seg         <= seg_d;
         dig_en      <= dig_en_d;
         upd_ack     <= load;
         frame_start <= frame_d;
         if (load) shadow_q <= digits;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (N=4, DWELL=4, GAP=2).
module tb_seven_seg_scan_ctrl;

   localparam int unsigned N     = 4;
   localparam int unsigned DWELL = 4;
   localparam int unsigned GAPC  = 2;
   localparam int unsigned SLOT  = DWELL + GAPC;
   localparam int unsigned FRAME = N * SLOT;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [15:0]   digits;
   logic          upd_req;
   logic          upd_ack;
   logic [6:0]    seg;
   logic [3:0]    dig_en;
   logic          frame_start;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [6:0]  tab [16] = '{7'b0111111, 7'b0001100, 7'b1011011, 7'b1011110,
                             7'b1101100, 7'b1110110, 7'b1110111, 7'b0011100,
                             7'b1111111, 7'b1111110, 7'b1111101, 7'b1100111,
                             7'b0110011, 7'b1001111, 7'b1110011, 7'b1110001};

   logic [15:0] sb_q [$];
   logic [15:0] exp_shadow = '0;
   logic        req_pend   = 1'b0;
   logic        was_dis    = 1'b0;
   int          pos        = 0;

   seven_seg_scan_ctrl #(
      .N_DIGITS     (N),
      .DWELL_CYCLES (DWELL),
      .GAP_CYCLES   (GAPC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .digits      (digits),
      .upd_req     (upd_req),
      .upd_ack     (upd_ack),
      .seg         (seg),
      .dig_en      (dig_en),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s pos=%0d t=%0t: observed %0h expected %0h", tag, pos, $time, obs, expv);
      end
   endtask

   function automatic logic [6:0] exp_seg(input logic [15:0] sh, input int k);
      logic [3:0] nib;
      logic       lead;
      nib  = sh[4*k +: 4];
      lead = 1'b1;
      for (int j = 3; j >= k; j--) lead = lead & (sh[4*j +: 4] == 4'h0);
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if (k > 0 && lead) return 7'b0000000;
`endif
      return tab[nib];
   endfunction

   // Advance one cycle and compare every output against the frame-position model.
   task automatic step();
      logic       req_seen, en_seen, exp_fs, exp_ack;
      logic [6:0] es;
      logic [3:0] ed;
      int         k, o;
      req_seen = upd_req;
      en_seen  = enable;
      @(negedge clk);
      exp_fs = 1'b0;
      es     = '0;
      ed     = '0;
      if (!en_seen) begin
         was_dis = 1'b1;
         pos     = 0;
      end else begin
         if (was_dis) begin
            was_dis = 1'b0;
            pos     = 0;
            exp_fs  = 1'b1;
         end else begin
            pos    = (pos + 1) % FRAME;
            exp_fs = (pos == 0);
         end
      end
      exp_ack  = exp_fs && (req_pend || req_seen);
      req_pend = (req_pend || req_seen) && !exp_ack;
      if (exp_ack && sb_q.size() > 0) exp_shadow = sb_q.pop_front();
      if (en_seen) begin
         k = pos / SLOT;
         o = pos % SLOT;
         if (o >= GAPC) begin
            ed = 4'b0001 << k;
            es = exp_seg(exp_shadow, k);
         end
      end
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
      chk("upd_ack",     32'(upd_ack),     32'(exp_ack));
      chk("seg",         32'(seg),         32'(es));
      chk("dig_en",      32'(dig_en),      32'(ed));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < int'(FRAME) + 1 && pos != target; i++) step();
   endtask

   task automatic pulse_req(input logic [15:0] d);
      digits  = d;
      upd_req = 1'b1;
      if (req_pend && sb_q.size() > 0) sb_q[sb_q.size()-1] = d;
      else                             sb_q.push_back(d);
      step();
      upd_req = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_seg"},    32'(seg),         32'd0);
      chk({tag, "_dig_en"}, 32'(dig_en),      32'd0);
      chk({tag, "_ack"},    32'(upd_ack),     32'd0);
      chk({tag, "_fs"},     32'(frame_start), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b1;
      upd_req = 1'b0;
      digits  = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      reset_n = 1'b1;
      pos     = 0;

      // Two frames with the reset shadow, first frame_start one frame after release.
      run(2 * FRAME);

      // Mid-frame request loads at the next wrap.
      run_to(10);
      pulse_req(16'h1A3F);
      run_to(0);
      run(FRAME);

      // Request coincident with the wrap: same-cycle ack, none the frame after.
      run_to(FRAME - 1);
      pulse_req(16'h0008);
      run(2 * FRAME);

      // Two requests before the wrap merge into one load of the latest value.
      run_to(3);
      pulse_req(16'h1111);
      run(2);
      pulse_req(16'h0070);
      run_to(0);
      run(FRAME);

      // Disable mid-SHOW with a pending request, then re-enable.
      run_to(8);
      pulse_req(16'hBEEF);
      enable = 1'b0;
      run(10);
      enable = 1'b1;
      run(FRAME + 2);

      // Asynchronous reset mid-SHOW drops the pending request and darkens at once.
      run_to(14);
      pulse_req(16'h2222);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_seg",    32'(seg),    32'd0);
      chk("async_dig_en", 32'(dig_en), 32'd0);
      @(negedge clk);
      chk_reset_vals("rst2");
      sb_q.delete();
      exp_shadow = '0;
      req_pend   = 1'b0;
      was_dis    = 1'b0;
      pos        = 0;
      reset_n    = 1'b1;
      run(FRAME + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
